// File: rtl/fuse_pkg.sv
// Shared types and constants for the edge/colour fusion sequencer.
package fuse_pkg;

    localparam int unsigned PIX_W = 24;

    typedef enum logic [1:0] {
        MODE_COLOR   = 2'd0,
        MODE_EDGE    = 2'd1,
        MODE_OVERLAY = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Overlay edge decision: blue byte of the edge pixel against the threshold.
    function automatic logic is_edge(input logic [PIX_W-1:0] px, input logic [7:0] thresh);
        return (px[7:0] >= thresh);
    endfunction

endpackage

// File: rtl/pixel_fifo2.sv
// Two-entry pixel FIFO with synchronous reset and synchronous clear.
module pixel_fifo2 #(
    parameter int unsigned DW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [1:0]    count
);

    logic [DW-1:0] r_mem [2];
    logic          r_wr;
    logic          r_rd;
    logic [1:0]    r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr] <= din;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (push) begin
                r_wr <= ~r_wr;
            end
            if (pop) begin
                r_rd <= ~r_rd;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd];
    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);
    assign count = r_count;

endmodule

// File: rtl/fuse_controller.sv
// Frame sequencer: joins the edge and colour streams pixel-for-pixel and emits
// one fused, coordinate-tagged stream per frame.
module fuse_controller
    import fuse_pkg::*;
#(
    parameter int unsigned      WIDTH      = 640,
    parameter int unsigned      HEIGHT     = 480,
    parameter int unsigned      XW         = 10,
    parameter int unsigned      YW         = 10,
    parameter logic [PIX_W-1:0] EDGE_COLOR = 24'h000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [7:0]       edge_thresh,
    input  logic [PIX_W-1:0] edge_pixel,
    input  logic             edge_valid,
    output logic             edge_ready,
    input  logic [PIX_W-1:0] color_pixel,
    input  logic             color_valid,
    output logic             color_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_sel_edge,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y,
    output logic             sof,
    output logic             eol,
    output logic             busy,
    output logic             done
);

    localparam int unsigned TOTAL = WIDTH * HEIGHT;
    localparam int unsigned CW    = $clog2(TOTAL + 1);

    state_e           r_state;
    mode_e            r_mode;
    logic [7:0]       r_thresh;
    logic [CW-1:0]    r_pair_cnt;
    logic [XW-1:0]    r_px;
    logic [YW-1:0]    r_py;
    logic [PIX_W-1:0] r_out_pixel;
    logic             r_out_sel;
    logic             r_out_valid;
    logic [XW-1:0]    r_out_x;
    logic [YW-1:0]    r_out_y;
    logic             r_sof;
    logic             r_eol;
    logic             r_busy;
    logic             r_done;

    logic [PIX_W-1:0] w_e_dout;
    logic [PIX_W-1:0] w_c_dout;
    logic             w_e_full;
    logic             w_c_full;
    logic             w_e_empty;
    logic             w_c_empty;
    logic [1:0]       w_e_count;
    logic [1:0]       w_c_count;
    logic             w_run;
    logic             w_e_push;
    logic             w_c_push;
    logic             w_pop;
    logic             w_out_hs;
    logic             w_last_hs;
    logic [PIX_W-1:0] w_sel_pix;
    logic             w_sel_edge;

    assign w_run       = (r_state == RUN);
    assign edge_ready  = w_run & (w_e_count < 2'd2);
    assign color_ready = w_run & (w_c_count < 2'd2);
    assign w_e_push    = edge_valid & edge_ready & ~w_e_full;
    assign w_c_push    = color_valid & color_ready & ~w_c_full;

    // Join: both sides present, output slot free or draining, frame not yet fully popped.
    assign w_pop = w_run & ~w_e_empty & ~w_c_empty
                 & (~r_out_valid | out_ready)
                 & (r_pair_cnt < CW'(TOTAL));

    assign w_out_hs  = w_run & r_out_valid & out_ready;
    assign w_last_hs = w_out_hs & (r_out_x == XW'(WIDTH - 1)) & (r_out_y == YW'(HEIGHT - 1));

    pixel_fifo2 #(.DW(PIX_W)) u_edge_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (w_last_hs),
        .push  (w_e_push),
        .din   (edge_pixel),
        .pop   (w_pop),
        .dout  (w_e_dout),
        .full  (w_e_full),
        .empty (w_e_empty),
        .count (w_e_count)
    );

    pixel_fifo2 #(.DW(PIX_W)) u_color_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (w_last_hs),
        .push  (w_c_push),
        .din   (color_pixel),
        .pop   (w_pop),
        .dout  (w_c_dout),
        .full  (w_c_full),
        .empty (w_c_empty),
        .count (w_c_count)
    );

    // Per-pixel source selection from the mode and threshold latched at frame start.
    always_comb begin
        w_sel_pix  = w_c_dout;
        w_sel_edge = 1'b0;
        case (r_mode)
            MODE_EDGE: begin
                w_sel_pix  = w_e_dout;
                w_sel_edge = 1'b1;
            end
            MODE_OVERLAY: begin
                if (is_edge(w_e_dout, r_thresh)) begin
                    w_sel_pix  = EDGE_COLOR;
                    w_sel_edge = 1'b1;
                end
            end
            default: begin
                w_sel_pix  = w_c_dout;
                w_sel_edge = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mode      <= MODE_COLOR;
            r_thresh    <= 8'd0;
            r_pair_cnt  <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_out_pixel <= '0;
            r_out_sel   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= RUN;
                        r_busy     <= 1'b1;
                        r_mode     <= mode_e'(mode);
                        r_thresh   <= edge_thresh;
                        r_pair_cnt <= '0;
                        r_px       <= '0;
                        r_py       <= '0;
                    end
                end
                RUN: begin
                    // Coordinates are assigned at pop time; beats leave strictly in pop order.
                    if (w_pop) begin
                        r_out_pixel <= w_sel_pix;
                        r_out_sel   <= w_sel_edge;
                        r_out_valid <= 1'b1;
                        r_out_x     <= r_px;
                        r_out_y     <= r_py;
                        r_sof       <= (r_px == '0) && (r_py == '0);
                        r_eol       <= (r_px == XW'(WIDTH - 1));
                        r_pair_cnt  <= r_pair_cnt + CW'(1);
                        if (r_px == XW'(WIDTH - 1)) begin
                            r_px <= '0;
                            r_py <= r_py + YW'(1);
                        end else begin
                            r_px <= r_px + XW'(1);
                        end
                    end else if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_last_hs) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_pixel    = r_out_pixel;
    assign out_sel_edge = r_out_sel;
    assign out_valid    = r_out_valid;
    assign out_x        = r_out_x;
    assign out_y        = r_out_y;
    assign sof          = r_sof;
    assign eol          = r_eol;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_fuse_controller.sv
// Directed + randomised bench for fuse_controller on a 4x2 frame against a
// pixel-index reference model.
module tb_fuse_controller;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned N  = W * H;
    localparam logic [23:0] EC = 24'h000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  edge_thresh;
    logic [23:0] edge_pixel;
    logic        edge_valid;
    logic        edge_ready;
    logic [23:0] color_pixel;
    logic        color_valid;
    logic        color_ready;
    logic [23:0] out_pixel;
    logic        out_sel_edge;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_x;
    logic [9:0]  out_y;
    logic        sof;
    logic        eol;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_err    = 0;

    logic [23:0] e_arr [N];
    logic [23:0] c_arr [N];

    always #5 clk = ~clk;

    fuse_controller #(.WIDTH(W), .HEIGHT(H), .XW(10), .YW(10), .EDGE_COLOR(EC)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .edge_thresh  (edge_thresh),
        .edge_pixel   (edge_pixel),
        .edge_valid   (edge_valid),
        .edge_ready   (edge_ready),
        .color_pixel  (color_pixel),
        .color_valid  (color_valid),
        .color_ready  (color_ready),
        .out_pixel    (out_pixel),
        .out_sel_edge (out_sel_edge),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_y        (out_y),
        .sof          (sof),
        .eol          (eol),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {sel, pixel} for one pixel pair under a frame mode.
    function automatic logic [24:0] model(input int m, input logic [7:0] th,
                                          input logic [23:0] e, input logic [23:0] c);
        logic [7:0] blue;
        blue = e[7:0];
        if (m == 1) return {1'b1, e};
        if (m == 2 && blue >= th) return {1'b1, EC};
        return {1'b0, c};
    endfunction

    task automatic run_frame(input int m, input logic [7:0] th, input int e_delay, input int c_delay,
                             input int stall_beat, input int stall_len, input int rst_beat,
                             input bit rnd, input int mid_mode);
        int cyc, e_idx, c_idx, o_idx, st_cnt, done_cnt, last_hs, first_ov, lat_ref;
        bit e_pend, c_pend, fin, stalling;
        logic [24:0] exp_v;
        cyc = 0; e_idx = 0; c_idx = 0; o_idx = 0; st_cnt = 0; done_cnt = 0;
        last_hs = -1; first_ov = -1; e_pend = 0; c_pend = 0; fin = 0;
        lat_ref = (e_delay > c_delay) ? e_delay : c_delay;

        @(negedge clk);
        mode = 2'(m); edge_thresh = th; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_run", 32'(busy), 32'd1);

        while (!fin && cyc < 400) begin
            if (mid_mode >= 0 && o_idx > 2) begin
                mode = 2'(mid_mode);
                edge_thresh = ~th;
            end
            if (!e_pend && e_idx < N && cyc >= e_delay && (!rnd || $urandom_range(0, 3) != 0)) e_pend = 1;
            if (!c_pend && c_idx < N && cyc >= c_delay && (!rnd || $urandom_range(0, 3) != 0)) c_pend = 1;
            edge_valid  = e_pend;
            edge_pixel  = e_pend ? e_arr[e_idx % N] : 24'h0;
            color_valid = c_pend;
            color_pixel = c_pend ? c_arr[c_idx % N] : 24'h0;
            stalling = (o_idx == stall_beat) && (st_cnt < stall_len);
            if (stalling) st_cnt++;
            out_ready = !stalling && (!rnd || $urandom_range(0, 2) != 0);

            if (stalling && st_cnt == 5) begin
                chk("stall_edge_ready", 32'(edge_ready), 32'd0);
                chk("stall_color_ready", 32'(color_ready), 32'd0);
            end
            if (c_delay > e_delay + 3 && cyc == c_delay - 1) begin
                chk("skew_edge_ready", 32'(edge_ready), 32'd0);
                chk("skew_edge_accepted", 32'(e_idx), 32'd2);
            end

            if (rst_beat >= 0 && o_idx == rst_beat) begin
                reset = 1'b1;
                edge_valid = 1'b0; color_valid = 1'b0; out_ready = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_edge_ready", 32'(edge_ready), 32'd0);
                chk("rst_color_ready", 32'(color_ready), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                fin = 1;
            end else begin
                if (o_idx >= N) begin
                    chk("no_extra_beat", 32'(out_valid), 32'd0);
                end else if (out_valid === 1'b1) begin
                    if (first_ov < 0) first_ov = cyc;
                    exp_v = model(m, th, e_arr[o_idx], c_arr[o_idx]);
                    chk("pixel", 32'(out_pixel), 32'(exp_v[23:0]));
                    chk("sel_edge", 32'(out_sel_edge), 32'(exp_v[24]));
                    chk("out_x", 32'(out_x), 32'(o_idx % W));
                    chk("out_y", 32'(out_y), 32'(o_idx / W));
                    chk("sof", 32'(sof), 32'(o_idx == 0));
                    chk("eol", 32'(eol), 32'((o_idx % W) == W - 1));
                    if (out_ready) begin
                        o_idx++;
                        if (o_idx == N) last_hs = cyc;
                    end
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    chk("done_timing", 32'(cyc), 32'(last_hs + 1));
                    chk("done_out_valid", 32'(out_valid), 32'd0);
                end
                if (e_pend && edge_ready === 1'b1) begin e_idx++; e_pend = 0; end
                if (c_pend && color_ready === 1'b1) begin c_idx++; c_pend = 0; end
                if (last_hs >= 0 && cyc >= last_hs + 3) fin = 1;
                @(negedge clk);
                cyc++;
            end
        end
        edge_valid = 1'b0; color_valid = 1'b0; out_ready = 1'b0;

        if (rst_beat >= 0) begin
            repeat (3) begin
                @(negedge clk);
                chk("no_done_after_reset", 32'(done), 32'd0);
            end
        end else begin
            chk("frame_complete", 32'(o_idx), 32'(N));
            chk("done_once", 32'(done_cnt), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            if (!rnd) chk("latency", 32'(first_ov - lat_ref), 32'd2);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 2'd0; edge_thresh = 8'd0;
        edge_pixel = '0; edge_valid = 1'b0; color_pixel = '0; color_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_edge_ready", 32'(edge_ready), 32'd0);
        chk("reset_color_ready", 32'(color_ready), 32'd0);
        chk("reset_out_pixel", 32'(out_pixel), 32'd0);
        chk("reset_out_x", 32'(out_x), 32'd0);
        chk("reset_sof", 32'(sof), 32'd0);
        reset = 1'b0;

        // Colour-only with constant inputs.
        for (int i = 0; i < int'(N); i++) begin e_arr[i] = 24'hFFFFFF; c_arr[i] = 24'hFF0000; end
        run_frame(0, 8'h00, 0, 0, -1, 0, -1, 1'b0, -1);

        // Overlay at the threshold boundary.
        for (int i = 0; i < int'(N); i++) begin
            e_arr[i] = (i % 2 == 1) ? 24'h123480 : 24'h12347F;
            c_arr[i] = 24'h00FF00;
        end
        run_frame(2, 8'h80, 0, 0, -1, 0, -1, 1'b0, -1);

        // Edge stream arrives five cycles ahead of colour.
        for (int i = 0; i < int'(N); i++) begin e_arr[i] = 24'($urandom); c_arr[i] = 24'($urandom); end
        run_frame(1, 8'h00, 0, 5, -1, 0, -1, 1'b0, -1);

        // Output stall mid-frame.
        for (int i = 0; i < int'(N); i++) begin e_arr[i] = 24'($urandom); c_arr[i] = 24'($urandom); end
        run_frame(2, 8'h80, 0, 0, 3, 6, -1, 1'b0, -1);

        // Mode input changes mid-frame; next frame picks up the new mode.
        for (int i = 0; i < int'(N); i++) begin e_arr[i] = 24'($urandom); c_arr[i] = 24'($urandom); end
        run_frame(0, 8'h40, 0, 0, -1, 0, -1, 1'b0, 1);
        run_frame(1, 8'h40, 0, 0, -1, 0, -1, 1'b0, -1);

        // Reset mid-frame, then a clean restart in the reserved mode.
        run_frame(0, 8'h00, 0, 0, -1, 0, 5, 1'b0, -1);
        for (int i = 0; i < int'(N); i++) begin e_arr[i] = 24'($urandom); c_arr[i] = 24'($urandom); end
        run_frame(3, 8'h00, 0, 0, -1, 0, -1, 1'b0, -1);

        // Randomised traffic, modes and thresholds.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < int'(N); i++) begin e_arr[i] = 24'($urandom); c_arr[i] = 24'($urandom); end
            run_frame(int'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), -1, 0, -1, 1'b1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fuse_controller.md
Name: fuse_controller

Overview:
- Frame-level sequencer for the edge/colour fusion stage. Accepts the edge-detector pixel stream and the colour-reduction pixel stream, each with its own valid/ready handshake, and aligns them pixel-for-pixel.
- Per pixel, decides the edge-vs-colour selection from a latched mode and threshold, then emits one fused, coordinate-tagged pixel stream with valid/ready.
- Sits between the two filter pipelines and the frame buffer writer; `start` is driven by the top-level FSM.

Parameters:
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- XW, 10, width of x coordinate
- YW, 10, width of y coordinate
- EDGE_COLOR, 24'h000000, pixel emitted on edges in overlay mode

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a frame when IDLE
- mode  in  2  0 colour-only, 1 edge-only, 2 overlay, 3 reserved (acts as 0)
- edge_thresh  in  8  overlay edge threshold
- edge_pixel  in  24  edge-detector pixel {R,G,B}
- edge_valid  in  1  edge_pixel valid
- edge_ready  out  1  edge beat accepted when edge_valid & edge_ready
- color_pixel  in  24  colour-reduced pixel
- color_valid  in  1  color_pixel valid
- color_ready  out  1  colour beat accepted when color_valid & color_ready
- out_pixel  out  24  fused pixel
- out_sel_edge  out  1  1 = out_pixel sourced from the edge path
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_x  out  XW  column of the current output beat
- out_y  out  YW  row of the current output beat
- sof  out  1  qualifies the beat at x=0, y=0
- eol  out  1  qualifies the beat at x=WIDTH-1
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (synchronous, active-high): state IDLE, both FIFOs empty, all outputs 0, counters 0.
- FSM:
  - IDLE → RUN on `start`. In the same cycle, latch `mode` and `edge_thresh`; later changes are ignored until the next frame.
  - RUN → DONE on the output handshake (out_valid & out_ready) of the beat with x=WIDTH-1, y=HEIGHT-1.
  - DONE → IDLE unconditionally after one cycle. `done`=1 only in DONE.
  - `start` is ignored outside IDLE.
- Input buffering:
  - Each input has a 2-entry FIFO.
  - *_ready = (state==RUN) & (registered count < 2). No push while full, even if a pop occurs in the same cycle.
  - Pushes and pops in the same cycle update the count correctly.
- Join:
  - Pop both FIFOs together when both are non-empty, (out_valid==0 or out_ready==1), state==RUN, and popped-pair count < WIDTH*HEIGHT.
  - The popped pair loads the output register next cycle.
  - Minimum latency from both inputs valid to out_valid is 2 cycles. Sustained throughput is 1 pixel/cycle when out_ready=1.
- Select rule for the loaded pair:
  - mode 0/3: out_pixel=color_pixel, sel=0.
  - mode 1: out_pixel=edge_pixel, sel=1.
  - mode 2: edge = (edge_pixel[7:0] >= thresh), unsigned. If edge, out_pixel=EDGE_COLOR and sel=1; else color_pixel and sel=0.
- Output hold: out_valid stays asserted and out_pixel/out_sel_edge/out_x/out_y/sof/eol are held stable until out_ready. No beat is dropped or duplicated.
- Coordinates:
  - x increments on each output handshake and wraps WIDTH-1→0; y increments on that wrap.
  - Both clear to 0 on IDLE→RUN.
  - sof = (x==0 & y==0); eol = (x==WIDTH-1). Both are meaningful only with out_valid.
- End of frame: surplus beats still buffered are discarded when DONE is entered (FIFOs cleared). out_valid=0 in DONE and IDLE.
- Reset mid-frame: immediate return to IDLE with all state cleared. No done pulse.

Decomposition:
- Shared package `fuse_pkg`:
  - mode encodings MODE_COLOR=0, MODE_EDGE=1, MODE_OVERLAY=2;
  - state encodings IDLE/RUN/DONE;
  - pixel width constant PIX_W=24.
- Sub-module `pixel_fifo2`: 2-entry FIFO with push/pop/full/empty/count and a synchronous clear, parameterised on data width. It is instantiated twice.

Test Plan (WIDTH=4, HEIGHT=2):
- Reset, then `start` with mode=0; drive 8 beats of colour 24'hFF0000 and edge 24'hFFFFFF; out_ready=1 → 8 beats of 24'hFF0000, sel=0, x sequence 0,1,2,3,0,1,2,3, y 0×4 then 1×4, sof on beat 0, eol on beats 3 and 7. `done` pulses once, one cycle after the last handshake.
- mode=2, thresh=8'h80; edge blue bytes alternate 8'h7F/8'h80, colour 24'h00FF00 → outputs alternate 24'h00FF00/sel=0 and 24'h000000/sel=1.
- Skewed arrival: edge stream arrives 5 cycles before colour → edge_ready drops after 2 beats. Outputs start 2 cycles after the first colour valid, and pairing stays in order.
- Backpressure: out_ready=0 for 6 cycles mid-frame → out_pixel/out_x held constant, both *_ready low once the FIFOs are full, no loss; resume yields the exact remaining sequence.
- Mode change mid-frame (mode 0→1 after beat 2) → all 8 beats still follow mode 0; the next frame follows mode 1.
- `reset` asserted at beat 5 → next cycle busy=0, out_valid=0, *_ready=0, no done. A following `start` restarts at x=0, y=0.
